// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 encodings,
// the FSM state enum and the data width.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Stores only have signed-size encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction/extension, sub-word store merge and
// misalignment flag (flag only active when LSU_MISALIGN_CHECK_EN is defined).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_value,
  output logic [XLEN-1:0] merged_word,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    // addr_lo[0] is ignored for halfwords, which aligns them down when unchecked.
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_value = {24'd0, byte_sel};
      F3_HU:   load_value = {16'd0, half_sel};
      default: load_value = word;
    endcase
    merged_word = word;
    case (funct3[1:0])
      2'b00:   merged_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
      2'b01:   merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (funct3[1:0])
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo;
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-only memory; sub-word stores run
// as read-modify-write. Optional LSU_MISALIGN_CHECK_EN enables fault responses.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_misalign,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_write_data,
  input  logic [XLEN-1:0]   mem_read_data
);
  import lsu_pkg::*;

  state_t            state, state_next;
  logic [ADDR_W-1:0] held_addr;
  logic [XLEN-1:0]   held_word;
  logic [XLEN-1:0]   load_value, merged_word;
  logic              misalign;
  logic              is_store, is_load, legal, req_fire, access, sub_store, fault;

  lsu_align u_align (
    .funct3      (req_funct3),
    .addr_lo     (req_addr[1:0]),
    .word        (mem_read_data),
    .store_data  (req_wdata),
    .load_value  (load_value),
    .merged_word (merged_word),
    .misalign    (misalign)
  );

  // Handshake: a request transfers in any cycle with req_valid && req_ready;
  // req_ready depends only on state, never on req_valid. Requests with neither
  // load nor store set are dropped without a response.
  assign req_ready = (state == IDLE);
  assign is_store  = req_is_store;
  assign is_load   = req_is_load && !req_is_store;
  assign legal     = f3_legal(is_store, req_funct3);
  assign req_fire  = req_valid && (state == IDLE) && (is_load || is_store);
  assign access    = req_fire && legal && !misalign;
  assign sub_store = access && is_store && (req_funct3 != F3_W);
  assign fault     = req_fire && legal && misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = {req_addr[ADDR_W-1:2], 2'b00};
    mem_write_data = req_wdata;
    case (state)
      IDLE: begin
        mem_read  = access && (is_load || sub_store);
        mem_write = access && is_store && !sub_store;
        if (sub_store) state_next = RMW_WR;
      end
      RMW_WR: begin
        mem_write      = 1'b1;
        mem_addr       = held_addr;
        mem_write_data = held_word;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Keep the memory quiet while reset is held, even mid-RMW.
    if (rst) begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
      held_addr    <= '0;
      held_word    <= '0;
    end else begin
      rsp_valid    <= (req_fire && !sub_store) || (state == RMW_WR);
      rsp_rdata    <= (access && is_load) ? load_value : '0;
      rsp_misalign <= fault;
      if (sub_store) begin
        held_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        held_word <= merged_word;
      end
    end
  end

endmodule
